snow3g_fsm: RTL and testbench

Finite-state-machine stage of the SNOW 3G keystream generator. It holds the FSM registers R1, R2 and R3 and sequences initialisation (32 clocks), the discard clock and keystream generation. It drives R1 into the existing 32-bit S1 box and R2 into the S2 box, and consumes their outputs as the next R2 and R3. It also computes F for the LFSR and produces registered keystream words with a valid/ready handshake.

---
 rtl/snow3g_fsm.sv | 121 ++++++++++++
 tb/tb_snow3g_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snow3g_fsm.sv
// SNOW 3G FSM stage: R1/R2/R3 registers, F computation and the
// init/discard/run sequencing that drives the LFSR and the keystream handshake.
module snow3g_fsm #(
  parameter int NUM_INIT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [31:0] s0,
  input  logic [31:0] s5,
  input  logic [31:0] s15,
  output logic [31:0] r1_out,
  input  logic [31:0] s1_in,
  output logic [31:0] r2_out,
  input  logic [31:0] s2_in,
  output logic [31:0] f_out,
  output logic        lfsr_step,
  output logic        lfsr_init_mode,
  output logic [31:0] z_out,
  output logic        z_valid,
  input  logic        z_ready,
  output logic        busy
);

  localparam int CW = $clog2(NUM_INIT + 1);

  typedef enum logic [1:0] {IDLE, INIT, DISCARD, RUN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   r1_q, r2_q, r3_q, z_q;
  logic          zv_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   rem_q;
  logic          step, accept, run_step, init_mode;

  assign f_out          = (s15 + r1_q) ^ r2_q;
  assign r1_out         = r1_q;
  assign r2_out         = r2_q;
  assign z_out          = z_q;
  assign z_valid        = zv_q;
  assign lfsr_step      = step;
  assign lfsr_init_mode = init_mode;
  assign busy           = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d   = state_q;
    step      = 1'b0;
    accept    = 1'b0;
    run_step  = 1'b0;
    init_mode = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        step      = 1'b1;
        init_mode = 1'b1;
        if (cnt_q == CW'(NUM_INIT - 1)) state_d = DISCARD;
      end
      DISCARD: begin
        step    = 1'b1;
        state_d = (rem_q == 16'd0) ? IDLE : RUN;
      end
      RUN: begin
        // Advance only when the output register is free or being emptied now.
        if (!zv_q || z_ready) begin
          step     = 1'b1;
          run_step = 1'b1;
          if (rem_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      z_q   <= '0;
      zv_q  <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
    end else begin
      if (accept) begin
        r1_q  <= '0;
        r2_q  <= '0;
        r3_q  <= '0;
        cnt_q <= '0;
        rem_q <= num_words;
      end else if (step) begin
        r1_q <= r2_q + (r3_q ^ s5);
        r2_q <= s1_in;
        r3_q <= s2_in;
      end
      if (state_q == INIT) cnt_q <= cnt_q + CW'(1);
      // A pending word is handed over in any state; a RUN step reloads it.
      if (run_step) begin
        z_q   <= f_out ^ s0;
        zv_q  <= 1'b1;
        rem_q <= rem_q - 16'd1;
      end else if (zv_q && z_ready) begin
        zv_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snow3g_fsm.sv
// Self-checking bench for snow3g_fsm: table-driven first-step arithmetic plus
// full sessions checked cycle by cycle against a model and a keystream scoreboard.
module tb_snow3g_fsm;

  logic        clk = 1'b0;
  logic        rst, start, z_ready;
  logic [15:0] num_words;
  logic [31:0] s0, s5, s15, s1_in, s2_in;
  logic [31:0] r1_out, r2_out, f_out, z_out;
  logic        lfsr_step, lfsr_init_mode, z_valid, busy;

  always #5 clk = ~clk;

  // Bench S-boxes: constants for the arithmetic vectors, mixing functions otherwise.
  logic        sb_const;
  logic [31:0] c1, c2;
  assign s1_in = sb_const ? c1 : ({r1_out[12:0], r1_out[31:13]} ^ 32'h9E3779B9);
  assign s2_in = sb_const ? c2 : (r2_out * 32'd2654435761 + 32'd1);

  snow3g_fsm #(.NUM_INIT(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .s0(s0), .s5(s5), .s15(s15),
    .r1_out(r1_out), .s1_in(s1_in), .r2_out(r2_out), .s2_in(s2_in),
    .f_out(f_out), .lfsr_step(lfsr_step), .lfsr_init_mode(lfsr_init_mode),
    .z_out(z_out), .z_valid(z_valid), .z_ready(z_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef enum int {M_IDLE, M_INIT, M_DISC, M_RUN} mst_t;
  mst_t        m_st;
  int          m_cnt;
  logic [15:0] m_rem;
  logic [31:0] m_r1, m_r2, m_r3, m_zo;
  logic        m_zv;
  logic [31:0] sb_q[$];
  int          n_step, n_init, n_xfer, n_zv;

  function automatic logic [31:0] msb1(input logic [31:0] x);
    return sb_const ? c1 : ({x[12:0], x[31:13]} ^ 32'h9E3779B9);
  endfunction

  function automatic logic [31:0] msb2(input logic [31:0] x);
    return sb_const ? c2 : (x * 32'd2654435761 + 32'd1);
  endfunction

  task automatic model_clear();
    m_st = M_IDLE; m_cnt = 0; m_rem = '0;
    m_r1 = '0; m_r2 = '0; m_r3 = '0; m_zo = '0; m_zv = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_clock();
    logic [31:0] n1, n2, n3;
    n1 = m_r2 + (m_r3 ^ s5);
    n2 = msb1(m_r1);
    n3 = msb2(m_r2);
    m_r1 = n1; m_r2 = n2; m_r3 = n3;
  endtask

  // One clock: compare settled outputs with the model, then advance both.
  task automatic cycle();
    logic [31:0] e_f, exp_z;
    logic        e_step, e_busy, e_init;
    #1;
    e_busy = (m_st != M_IDLE);
    e_init = (m_st == M_INIT);
    e_step = (m_st == M_INIT) || (m_st == M_DISC) || (m_st == M_RUN && (!m_zv || z_ready));
    e_f    = (s15 + m_r1) ^ m_r2;
    if (chk_en) begin
      check("r1_out", r1_out, m_r1);
      check("r2_out", r2_out, m_r2);
      check("f_out", f_out, e_f);
      check("lfsr_step", 32'(lfsr_step), 32'(e_step));
      check("lfsr_init_mode", 32'(lfsr_init_mode), 32'(e_init));
      check("busy", 32'(busy), 32'(e_busy));
      check("z_valid", 32'(z_valid), 32'(m_zv));
      check("z_out", z_out, m_zo);
      if (m_zv && z_ready && !rst) begin
        if (sb_q.size() == 0) begin
          check("scoreboard_nonempty", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_z = sb_q.pop_front();
          check("z_word", z_out, exp_z);
        end
      end
    end
    if (lfsr_step === 1'b1)      n_step++;
    if (lfsr_init_mode === 1'b1) n_init++;
    if (z_valid === 1'b1)        n_zv++;
    if (z_valid === 1'b1 && z_ready && !rst) n_xfer++;

    if (rst) begin
      model_clear();
    end else begin
      if (m_zv && z_ready) m_zv = 1'b0;
      case (m_st)
        M_IDLE: if (start) begin
          m_cnt = 0; m_rem = num_words;
          m_r1 = '0; m_r2 = '0; m_r3 = '0;
          m_st = M_INIT;
        end
        M_INIT: begin
          model_clock();
          if (m_cnt == 31) m_st = M_DISC;
          m_cnt++;
        end
        M_DISC: begin
          model_clock();
          m_st = (m_rem == 16'd0) ? M_IDLE : M_RUN;
        end
        M_RUN: if (e_step) begin
          sb_q.push_back(e_f ^ s0);
          m_zo = e_f ^ s0;
          m_zv = 1'b1;
          model_clock();
          if (m_rem == 16'd1) m_st = M_IDLE;
          m_rem = m_rem - 16'd1;
        end
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk);
    #2;
  endtask

  // A full session with random LFSR words; optional injected start, stall and reset.
  task automatic session(input int nw, input int inj_start_at, input int stall_from,
                         input int rst_at, input int budget);
    int  runc;
    bit  done;
    n_step = 0; n_init = 0; n_xfer = 0; n_zv = 0;
    runc = 0; done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      rst       = (i == rst_at);
      start     = (i == 0) || (i == inj_start_at);
      num_words = (i == 0) ? 16'(nw) : 16'd7;
      s0        = $urandom;
      s5        = $urandom;
      s15       = $urandom;
      z_ready   = !(stall_from >= 0 && m_st == M_RUN &&
                    runc >= stall_from && runc < stall_from + 5);
      if (m_st == M_RUN) runc++;
      cycle();
      if (m_st == M_IDLE && !m_zv) done = 1'b1;
    end
    check("session_done", 32'(done), 32'd1);
    rst = 1'b0; start = 1'b0; z_ready = 1'b1;
  endtask

  typedef struct {
    logic [31:0] s5, s15, c1, c2;
    logic [31:0] r1_a, f_a, r1_b;
  } vec_t;
  vec_t vecs[4];

  initial begin
    // s5, s15, S1 const, S2 const, R1 after step 1, F in cycle 2, R1 after step 2
    vecs[0] = '{32'h00000001, 32'h00000002, 32'hAAAAAAAA, 32'h55555555,
                32'h00000001, 32'hAAAAAAA9, 32'hFFFFFFFE};
    vecs[1] = '{32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                32'h00000002, 32'hFFFFFFFD, 32'h00000001};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h0000000F,
                32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFF0};
    vecs[3] = '{32'h12345678, 32'h11111111, 32'h00000000, 32'h12345678,
                32'h12345678, 32'h23456789, 32'h00000000};

    rst = 1'b1; start = 1'b0; num_words = '0; z_ready = 1'b0;
    s0 = '0; s5 = '0; s15 = '0;
    sb_const = 1'b0; c1 = '0; c2 = '0;
    model_clear();
    chk_en = 1'b0;
    #2;
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_z_valid", 32'(z_valid), 32'd0);
    check("rst_z_out", z_out, 32'd0);
    check("rst_lfsr_step", 32'(lfsr_step), 32'd0);
    check("rst_init_mode", 32'(lfsr_init_mode), 32'd0);
    check("rst_f_out_zero", f_out, 32'd0);
    s15 = 32'h12345678;
    #1;
    check("rst_f_out_s15", f_out, 32'h12345678);
    cycle();

    foreach (vecs[k]) begin
      sb_const = 1'b1; c1 = vecs[k].c1; c2 = vecs[k].c2;
      rst = 1'b1; z_ready = 1'b1;
      cycle();
      rst = 1'b0;
      s5 = vecs[k].s5; s15 = vecs[k].s15; start = 1'b1;
      cycle();
      start = 1'b0;
      check("step1_f_out", f_out, vecs[k].s15);
      check("step1_init_mode", 32'(lfsr_init_mode), 32'd1);
      cycle();
      check("step1_r1", r1_out, vecs[k].r1_a);
      check("step1_r2", r2_out, vecs[k].c1);
      check("step2_f_out", f_out, vecs[k].f_a);
      cycle();
      check("step2_r1_wrap", r1_out, vecs[k].r1_b);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0; sb_const = 1'b0;
    cycle();

    session(3, -1, -1, -1, 200);
    check("seq_init_cycles", 32'(n_init), 32'd32);
    check("seq_steps", 32'(n_step), 32'd36);
    check("seq_words", 32'(n_xfer), 32'd3);
    check("seq_busy_end", 32'(busy), 32'd0);

    session(6, -1, 2, -1, 200);
    check("stall_words", 32'(n_xfer), 32'd6);
    check("stall_steps", 32'(n_step), 32'd39);

    session(0, -1, -1, -1, 200);
    check("zero_steps", 32'(n_step), 32'd33);
    check("zero_valid_cycles", 32'(n_zv), 32'd0);

    session(4, 5, -1, -1, 200);
    check("inj_start_words", 32'(n_xfer), 32'd4);
    check("inj_start_init", 32'(n_init), 32'd32);

    session(5, -1, -1, 36, 200);
    check("rst_run_r1", r1_out, 32'd0);
    check("rst_run_r2", r2_out, 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_z_valid", 32'(z_valid), 32'd0);
    check("rst_run_z_out", z_out, 32'd0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
